// File: rtl/win_overlay_ctrl.sv
// Win-screen overlay controller.
// Scales the screen position down to a picture ROM address and feeds the ROM
// index straight to the external win palette. The palette colour is then
// alpha-blended against the game background. A fade-in / hold / fade-out
// state machine moves alpha one step per FADE_FRAMES frames, so the picture
// changes only on frame boundaries.
// Pixel path (3 cycles): C1 address + flags, C2 ROM/palette data meets the
// delayed background, C3 registered blend.
module win_overlay_ctrl #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_LOG2  = 2,
  parameter int ADDR_W      = 15,
  parameter int FADE_FRAMES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              win,
  input  logic              key_continue,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_index,
  output logic [4:0]        pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              busy
);

  // Frame counter is at least one bit wide even when FADE_FRAMES is 1.
  localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FADE_FRAMES - 1);
  localparam logic [9:0]        IMG_W_C   = 10'(IMG_W);
  localparam logic [9:0]        IMG_H_C   = 10'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [4:0]        ALPHA_MAX = 5'd16;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FADE_IN  = 2'd1;
  localparam logic [1:0] S_SHOW     = 2'd2;
  localparam logic [1:0] S_FADE_OUT = 2'd3;

  // (pic*a + bg*(16-a)) >> 4 for a in 0..16; the sum never exceeds 240.
  function automatic logic [3:0] blend(input logic [3:0] pic,
                                       input logic [3:0] bgc,
                                       input logic [4:0] a);
    logic [8:0] sum;
    sum = 9'(pic) * 9'(a) + 9'(bgc) * 9'(ALPHA_MAX - a);
    return 4'(sum >> 4);
  endfunction

  // Fade control state
  logic [1:0]        r_state;
  logic [4:0]        r_alpha;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_state_n;
  logic [4:0]        w_alpha_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic              w_cnt_last;

  // Pixel pipeline
  logic [9:0]        w_col;
  logic [9:0]        w_row;
  logic              w_in_img;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_in_img_p1, r_in_img_p2;
  logic              r_blank_p1,  r_blank_p2;
  logic [3:0]        r_bgr_p1, r_bgg_p1, r_bgb_p1;
  logic [3:0]        r_bgr_p2, r_bgg_p2, r_bgb_p2;
  logic [4:0]        w_alpha_eff;
  logic [3:0]        w_red, w_green, w_blue;
  logic [3:0]        r_red, r_green, r_blue;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Next-state logic: a state change always beats an alpha step and clears the counter.
  always_comb begin
    w_state_n = r_state;
    w_alpha_n = r_alpha;
    w_cnt_n   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_alpha_n = 5'd0;
        w_cnt_n   = '0;
        if (win) w_state_n = S_FADE_IN;
      end
      S_FADE_IN: begin
        if (key_continue) begin
          w_state_n = S_FADE_OUT;
          w_cnt_n   = '0;
        end else if (r_alpha >= ALPHA_MAX) begin
          // Re-entered from a fade-out that had not yet stepped below 16.
          w_state_n = S_SHOW;
          w_alpha_n = ALPHA_MAX;
          w_cnt_n   = '0;
        end else if (frame_start) begin
          if (w_cnt_last) begin
            w_cnt_n   = '0;
            w_alpha_n = r_alpha + 5'd1;
            if (r_alpha == ALPHA_MAX - 5'd1) w_state_n = S_SHOW;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
      end
      S_SHOW: begin
        w_alpha_n = ALPHA_MAX;
        w_cnt_n   = '0;
        if (key_continue) w_state_n = S_FADE_OUT;
      end
      S_FADE_OUT: begin
        if (win) begin
          w_state_n = S_FADE_IN;
          w_cnt_n   = '0;
        end else if (r_alpha == 5'd0) begin
          // Dismissed a fade-in that had not yet left zero: nothing to fade.
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else if (frame_start) begin
          if (w_cnt_last) begin
            w_cnt_n   = '0;
            w_alpha_n = r_alpha - 5'd1;
            if (r_alpha == 5'd1) w_state_n = S_IDLE;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_alpha_n = 5'd0;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Fade state registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_alpha <= 5'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_alpha <= w_alpha_n;
      r_cnt   <= w_cnt_n;
    end
  end

  assign busy = (r_state != S_IDLE);

  // Screen position to picture coordinates; off-picture pixels read address 0.
  assign w_col    = DrawX >> SCALE_LOG2;
  assign w_row    = DrawY >> SCALE_LOG2;
  assign w_in_img = (w_col < IMG_W_C) && (w_row < IMG_H_C);
  assign w_addr   = w_in_img ? (ADDR_W'(w_row) * IMG_W_A + ADDR_W'(w_col)) : '0;

  // C1: register ROM address and capture flags/background.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rom_addr  <= '0;
      r_in_img_p1 <= 1'b0;
      r_blank_p1  <= 1'b0;
      r_bgr_p1    <= 4'd0;
      r_bgg_p1    <= 4'd0;
      r_bgb_p1    <= 4'd0;
    end else begin
      r_rom_addr  <= w_addr;
      r_in_img_p1 <= w_in_img;
      r_blank_p1  <= blank;
      r_bgr_p1    <= bg_red;
      r_bgg_p1    <= bg_green;
      r_bgb_p1    <= bg_blue;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign pal_index = rom_index;

  // C2: second delay so flags and background line up with the palette colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_in_img_p2 <= 1'b0;
      r_blank_p2  <= 1'b0;
      r_bgr_p2    <= 4'd0;
      r_bgg_p2    <= 4'd0;
      r_bgb_p2    <= 4'd0;
    end else begin
      r_in_img_p2 <= r_in_img_p1;
      r_blank_p2  <= r_blank_p1;
      r_bgr_p2    <= r_bgr_p1;
      r_bgg_p2    <= r_bgg_p1;
      r_bgb_p2    <= r_bgb_p1;
    end
  end

  // Alpha is sampled here; it only moves on frame_start, so a frame never tears.
  assign w_alpha_eff = r_in_img_p2 ? r_alpha : 5'd0;
  assign w_red       = r_blank_p2 ? blend(pal_red,   r_bgr_p2, w_alpha_eff) : 4'd0;
  assign w_green     = r_blank_p2 ? blend(pal_green, r_bgg_p2, w_alpha_eff) : 4'd0;
  assign w_blue      = r_blank_p2 ? blend(pal_blue,  r_bgb_p2, w_alpha_eff) : 4'd0;

  // C3: register the final pixel colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
    end
  end

  assign red   = r_red;
  assign green = r_green;
  assign blue  = r_blue;

endmodule

// File: tb/tb_win_overlay_ctrl.sv
// Directed bench for win_overlay_ctrl: pipeline alignment, addressing,
// fade sequencing, blend arithmetic, event priority and mid-fade reset.
module tb_win_overlay_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start, win, key_continue;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [14:0] rom_addr;
  logic [4:0]  rom_index, pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        busy;

  int checks = 0;
  int errors = 0;

  win_overlay_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .win(win),
    .key_continue(key_continue), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_index(rom_index), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference blend: weighted average of picture and background, floored.
  function automatic logic [3:0] mix(input int p, input int b, input int a);
    int s;
    s = p * a + b * (16 - a);
    return 4'(s / 16);
  endfunction

  // Expected pixel for the fade pattern pal=(F,0,F), bg=(0,F,1).
  function automatic logic [11:0] fade_rgb(input int a);
    return {mix(15, 0, a), mix(0, 15, a), mix(15, 1, a)};
  endfunction

  // One frame_start pulse, then let the steady pixel settle through the pipe.
  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; win = 1'b0; key_continue = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
    bg_red = 4'd0; bg_green = 4'd0; bg_blue = 4'd0;
    rom_index = 5'd7; pal_red = 4'd0; pal_green = 4'd0; pal_blue = 4'd0;
    tick();
    tick();
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_busy", busy, 1'b0);
    check("reset_addr", rom_addr, 15'd0);

    // Idle: pure background, address tracks position.
    Reset = 1'b0;
    DrawX = 10'd5; DrawY = 10'd9; blank = 1'b1;
    bg_red = 4'd3; bg_green = 4'd5; bg_blue = 4'd7;
    pal_red = 4'hF; pal_green = 4'h0; pal_blue = 4'hF;
    tick();
    check("addr_5_9", rom_addr, 15'd321);
    check("pal_index", pal_index, 5'd7);
    tick();
    check("latency_not_yet", {red, green, blue}, 12'h000);
    tick();
    check("idle_bg", {red, green, blue}, 12'h357);
    check("idle_busy", busy, 1'b0);

    // Fade in from the win pulse.
    DrawX = 10'd0; DrawY = 10'd0;
    bg_red = 4'h0; bg_green = 4'hF; bg_blue = 4'h1;
    tick(); tick(); tick();
    win = 1'b1;
    tick();
    win = 1'b0;
    check("win_busy", busy, 1'b1);
    for (int p = 1; p <= 64; p++) begin
      frame_pulse();
      check("fade_in", {red, green, blue}, fade_rgb(p / 4));
      if (p == 32) check("alpha8", {red, green, blue}, 12'h778);
    end

    // Show: full picture, frame pulses and win have no effect.
    pal_red = 4'hF; pal_green = 4'hA; pal_blue = 4'h6;
    tick(); tick(); tick();
    check("show_pic", {red, green, blue}, 12'hFA6);
    win = 1'b1; frame_start = 1'b1;
    tick();
    win = 1'b0; frame_start = 1'b0;
    tick(); tick();
    check("show_hold", {red, green, blue}, 12'hFA6);
    check("show_busy", busy, 1'b1);

    // Off-picture column: address 0 and background only.
    DrawX = 10'd640; DrawY = 10'd0;
    bg_red = 4'h2; bg_green = 4'h4; bg_blue = 4'h9;
    tick();
    check("addr_offimg", rom_addr, 15'd0);
    tick(); tick();
    check("offimg_bg", {red, green, blue}, 12'h249);

    // Blanking forces black, aligned to 3 cycles.
    DrawX = 10'd0;
    tick(); tick(); tick();
    check("pre_blank", {red, green, blue}, 12'hFA6);
    blank = 1'b0;
    tick(); tick();
    check("blank_align", {red, green, blue}, 12'hFA6);
    tick();
    check("blank_black", {red, green, blue}, 12'h000);
    blank = 1'b1;
    tick(); tick(); tick();

    // Fade out after dismiss.
    pal_red = 4'hF; pal_green = 4'h0; pal_blue = 4'hF;
    bg_red = 4'h0; bg_green = 4'hF; bg_blue = 4'h1;
    tick(); tick(); tick();
    key_continue = 1'b1;
    tick();
    key_continue = 1'b0;
    for (int p = 1; p <= 64; p++) begin
      frame_pulse();
      check("fade_out", {red, green, blue}, fade_rgb(16 - p / 4));
    end
    check("fade_out_idle", busy, 1'b0);

    // win and key together in IDLE: win wins.
    win = 1'b1; key_continue = 1'b1;
    tick();
    win = 1'b0; key_continue = 1'b0;
    check("idle_win_prio", busy, 1'b1);
    for (int p = 1; p <= 20; p++) frame_pulse();
    check("alpha5", {red, green, blue}, fade_rgb(5));

    // Fade out from 5 with a partial count, then win together with frame_start.
    key_continue = 1'b1;
    tick();
    key_continue = 1'b0;
    frame_pulse();
    frame_pulse();
    check("fo_partial", {red, green, blue}, fade_rgb(5));
    win = 1'b1; frame_start = 1'b1;
    tick();
    win = 1'b0; frame_start = 1'b0;
    tick(); tick();
    check("rewin_alpha", {red, green, blue}, fade_rgb(5));
    check("rewin_busy", busy, 1'b1);
    frame_pulse(); frame_pulse(); frame_pulse();
    check("rewin_cnt_clear", {red, green, blue}, fade_rgb(5));
    frame_pulse();
    check("rewin_step", {red, green, blue}, fade_rgb(6));

    // Reset mid-fade: black for three cycles, then background.
    bg_red = 4'h3; bg_green = 4'h5; bg_blue = 4'h7;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_rgb0", {red, green, blue}, 12'h000);
    tick();
    check("rst_rgb1", {red, green, blue}, 12'h000);
    tick();
    check("rst_rgb2", {red, green, blue}, 12'h000);
    tick();
    check("rst_bg", {red, green, blue}, 12'h357);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
